// File: rtl/fetch_responder.sv
// fetch_responder: dual-channel instruction supply from one shared program memory, with NOP feed for disabled channels.
// Optional build macro FETCH_RESPONDER_COUNT_EN adds saturating per-channel served-fetch counters.
module fetch_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_1_i,
    input  logic                     enable_2_i,
    input  logic                     req_valid_1_i,
    input  logic [31:0]              req_addr_1_i,
    output logic                     req_ready_1_o,
    output logic                     rsp_valid_1_o,
    output logic [31:0]              rsp_data_1_o,
    input  logic                     req_valid_2_i,
    input  logic [31:0]              req_addr_2_i,
    output logic                     req_ready_2_o,
    output logic                     rsp_valid_2_o,
    output logic [31:0]              rsp_data_2_o,
    output logic                     fetch_1_o,
    output logic                     fetch_2_o,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [31:0]              prog_data_i,
`ifdef FETCH_RESPONDER_COUNT_EN
    output logic [31:0]              served_1_o,
    output logic [31:0]              served_2_o,
`endif
    output logic                     fault_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    logic [1:0]    w_en, w_vld, w_mem, w_need, w_pick, w_rdy, w_acc, w_gnt;
    logic [31:0]   w_addr [2];
    logic [31:0]   w_off [2];
    logic [AW-1:0] w_idx [2];
    state_t        w_nx [2];
    state_t        r_st [2];
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_data [2];
    logic [1:0]    r_fetch;
    logic          r_ptr;
    logic          r_fault;

    assign w_en      = {enable_2_i, enable_1_i};
    assign w_vld     = {req_valid_2_i, req_valid_1_i};
    assign w_addr[0] = req_addr_1_i;
    assign w_addr[1] = req_addr_2_i;

    // Decode each address; w_mem marks an enabled channel whose address really hits memory
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_off[n] = w_addr[n] - BASE_ADDR;
            w_idx[n] = w_off[n][2 +: AW];
            w_mem[n] = w_en[n] && (w_off[n][1:0] == 2'b00) && ((w_off[n] >> 2) < 32'(DEPTH));
        end
        w_need = w_mem & w_vld;
    end

    // Single read port: a write blocks all reads, contention goes to r_ptr (0 = channel 1)
    always_comb begin
        w_pick[0] = !prog_we_i && (!w_need[1] || !r_ptr);
        w_pick[1] = !prog_we_i && (!w_need[0] || r_ptr);
        w_rdy     = rst_i ? 2'b00 : (~w_mem | w_pick);
        w_acc     = w_rdy & w_vld;
        w_gnt     = w_acc & w_mem;
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (prog_we_i) r_mem[prog_addr_i] <= prog_data_i;
    end

    // Response data, fetch pulses, round-robin pointer and sticky fault
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_fetch   <= '0;
            r_ptr     <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++)
                if (w_acc[n]) r_data[n] <= w_gnt[n] ? r_mem[w_idx[n]] : NOP_INSTR;
            r_fetch <= w_gnt;
            if (&w_need && !prog_we_i) r_ptr <= ~r_ptr;
            if (|(w_acc & w_en & ~w_mem)) r_fault <= 1'b1;
        end
    end

    // Per-channel response state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st[0] <= IDLE;
            r_st[1] <= IDLE;
        end else begin
            r_st[0] <= w_nx[0];
            r_st[1] <= w_nx[1];
        end
    end

    // Every acceptance (re)enters RESP for exactly the following cycle
    always_comb begin
        for (int n = 0; n < 2; n++) w_nx[n] = w_acc[n] ? RESP : IDLE;
    end

`ifdef FETCH_RESPONDER_COUNT_EN
    logic [31:0] r_served [2];

    // Saturating count of granted fetches per channel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_served[0] <= '0;
            r_served[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++)
                if (w_gnt[n] && r_served[n] != '1) r_served[n] <= r_served[n] + 32'd1;
        end
    end

    assign served_1_o = r_served[0];
    assign served_2_o = r_served[1];
`endif

    assign req_ready_1_o = w_rdy[0];
    assign req_ready_2_o = w_rdy[1];
    assign rsp_valid_1_o = (r_st[0] == RESP);
    assign rsp_valid_2_o = (r_st[1] == RESP);
    assign rsp_data_1_o  = r_data[0];
    assign rsp_data_2_o  = r_data[1];
    assign fetch_1_o     = r_fetch[0];
    assign fetch_2_o     = r_fetch[1];
    assign fault_o       = r_fault;
endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
- Instruction-supply side of the dual-core fetch-gating scheme in the verification harness.
- Answers fetch requests from two core instances (channel 1, channel 2) out of one shared, preloadable program memory.
- Emits a one-cycle fetch pulse per served instruction. These pulses feed the run controller's fetch inputs.
- Takes each channel's enable back from the controller. A disabled channel is fed NOPs so the core drains harmlessly.

Parameters:
DEPTH, 1024, program memory depth in 32-bit words; power of two, >= 2
BASE_ADDR, 32'h8000_0000, byte address of memory word 0
NOP_INSTR, 32'h0000_0013, word returned for disabled channels and faulting fetches

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
enable_1_i  input  1  channel 1 fetch enable from run controller
enable_2_i  input  1  channel 2 fetch enable from run controller
req_valid_1_i  input  1  channel 1 fetch request
req_addr_1_i  input  32  channel 1 byte address
req_ready_1_o  output  1  channel 1 request accepted this cycle
rsp_valid_1_o  output  1  channel 1 response valid (single-cycle pulse)
rsp_data_1_o  output  32  channel 1 instruction word
req_valid_2_i / req_addr_2_i / req_ready_2_o / rsp_valid_2_o / rsp_data_2_o  as channel 1, for channel 2
fetch_1_o  output  1  pulse: channel 1 served a real memory fetch
fetch_2_o  output  1  pulse: channel 2 served a real memory fetch
prog_we_i  input  1  program memory write strobe
prog_addr_i  input  $clog2(DEPTH)  word index for write
prog_data_i  input  32  write data
fault_o  output  1  sticky: some enabled channel requested an out-of-range or misaligned address

Behaviour:
- Reset values: all req_ready 0, rsp_valid 0, rsp_data 0, fetch pulses 0, fault_o 0, round-robin pointer set to channel 1. Memory contents are not reset.
- A reset asserted mid-operation discards any pending response. No rsp_valid appears in the cycle after reset.
- Handshake: a request is accepted in a cycle where req_valid and req_ready are both 1. The response is issued exactly 1 cycle later: rsp_valid pulses for one cycle, with no backpressure. Back-to-back acceptance on the same channel is allowed.
- Address decode: offset = addr - BASE_ADDR (32-bit wrap). Valid iff offset[1:0] == 0 and offset>>2 < DEPTH. Index = offset[2 +: $clog2(DEPTH)].
- Channel classification each cycle:
  - Disabled channel (enable low): req_ready = 1, no memory access. The response is NOP_INSTR, no fetch pulse, fault unaffected.
  - Enabled channel, invalid address: req_ready = 1, no memory access. The response is NOP_INSTR, no fetch pulse, and fault_o is set sticky on acceptance.
  - Enabled channel, valid address: needs the single memory read port.
- Memory port arbitration, in priority order:
  - prog_we_i high: the write wins and both memory-needing channels see req_ready = 0.
  - Only one channel needs the port: that channel is granted.
  - Both need it: grant goes to the round-robin pointer's channel, the other sees req_ready = 0. The pointer then flips to the loser. The pointer updates only on a contended grant.
- A granted fetch returns mem[index] next cycle. fetch_N_o pulses in the same cycle as rsp_valid_N_o, never otherwise.
- Write/read collision to the same index in the same cycle cannot occur, because a write blocks reads.
- Enable sampling: enable is sampled in the acceptance cycle. An enable that falls while a response is pending does not alter that response.
- Per-channel response FSM: IDLE -> RESP on acceptance. RESP -> RESP on a new acceptance, RESP -> IDLE otherwise.

Optional Feature:
FETCH_RESPONDER_COUNT_EN:
- Defined: adds outputs served_1_o and served_2_o, each 32 bits. Each counts the fetch pulses on its channel, resets to 0, and saturates at 32'hFFFF_FFFF (no wrap).
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Preload words 0..3 = 0x11,0x22,0x33,0x44. Ch1 requests BASE_ADDR+4, enabled -> next cycle rsp_data_1 = 0x22, rsp_valid_1 = 1, fetch_1 = 1.
- Both channels enabled, both request valid addresses on every cycle for 4 cycles -> grants alternate ch1, ch2, ch1, ch2. Each loser sees req_ready 0.
- enable_2 = 0, ch2 requests BASE_ADDR -> rsp_data_2 = 0x13, fetch_2 stays 0, ch1 traffic unaffected.
- Ch1 enabled requests BASE_ADDR+2 (misaligned), then BASE_ADDR+4*DEPTH (out of range) -> both responses are 0x13, fault_o = 1 and stays 1 until reset.
- prog_we_i held for 2 cycles while both channels request -> both req_ready = 0 for 2 cycles, then normal service resumes.
- Assert rst_i in the cycle after acceptance -> no rsp_valid, fault_o = 0, and the pointer is back on channel 1 (first contended grant goes to ch1).
